mux_rr: RTL
===========

# mux_rr

Four-lane round-robin merge: the counterpart of the 1-to-4 lane demux. It drains up to four upstream show-ahead FIFOs onto a single registered output stream. Each cycle it grants at most one non-empty lane, pops that lane's FIFO and forwards the word with a valid flag and the lane index. It sits between the per-lane FIFOs and the shared downstream FIFO, and honours that FIFO's pause (almost-full) flag.

## Interface
Parameters:
- DATA_WIDTH, 4, width of every data word.

Ports (clock and reset first):
- clk  input  1  single clock; all state updates on the rising edge.
- reset_L  input  1  asynchronous, active-low reset.
- enb  input  1  block enable; low means no grants.
- pausa  input  1  downstream almost-full; high means no grants.
- entrada0_mux..entrada3_mux  input  DATA_WIDTH each  head word of lane FIFO 0..3, show-ahead (valid while the matching vacio is low).
- vacio0_mux..vacio3_mux  input  1 each  lane FIFO 0..3 empty.
- pop0_mux..pop3_mux  output  1 each  combinational pop to lane FIFO 0..3; at most one high per cycle.
- salida_mux  output  DATA_WIDTH  registered forwarded word.
- valid_mux  output  1  registered; high means salida_mux holds a word.
- selector_mux  output  2  registered lane index of the current salida_mux.
- cuenta_mux  output  8  registered count of words forwarded.

## Operation
- Internal round-robin pointer ptr (2 bits) names the highest-priority lane. Priority order is ptr, ptr+1, ptr+2, ptr+3, all mod 4.
- A grant is allowed when enb=1 and pausa=0. The granted lane g is the first lane in priority order with vacio=0.
- On a grant:
  - pop_g=1 in the same cycle; all other pops are 0.
  - At the clock edge: salida_mux←entrada_g, selector_mux←g, valid_mux←1, ptr←g+1 mod 4, cuenta_mux←cuenta_mux+1.
- When no grant occurs (all lanes empty, enb=0 or pausa=1):
  - All pops are 0.
  - At the clock edge: valid_mux←0 and salida_mux←0. selector_mux, ptr and cuenta_mux hold.
- cuenta_mux wraps modulo 256: 255→0 on the next grant. It has no saturation.
- pausa and enb carry equal weight. Either one blocks grants in the same cycle.
- Fairness: a continuously non-empty lane is granted within 4 consecutive grant cycles.

## Timing
- Reset (reset_L=0, asynchronous, takes effect immediately):
  - salida_mux=0, valid_mux=0, selector_mux=0, cuenta_mux=0, ptr=0.
  - All pops are 0 while reset_L=0, regardless of the other inputs.
- Latency: a pop in cycle N produces valid_mux=1 with that word in cycle N+1. Throughput is one word per cycle.
- pops depend combinationally on vacio*, enb, pausa, reset_L and ptr only. They never depend on entrada*.
- pausa asserted in cycle N: no pop in cycle N, and valid_mux=0 in cycle N+1. A word already registered in cycle N is still presented in cycle N; downstream is sized to absorb it.
- Reset asserted mid-stream: the word in flight is discarded. Any pop already issued in that cycle is suppressed.
- First grant after reset release follows lane 0 priority.

## Structure
- Shared package holds:
  - lane count constant NUM_LANES=4.
  - selector width constant SEL_WIDTH=2.
  - counter width constant CNT_WIDTH=8.
- Sub-module rr_arbitro: purely combinational rotate-priority encoder.
  - Inputs: 4-bit request vector (~vacio & grant-allowed) and ptr.
  - Outputs: one-hot grant vector, 2-bit index and an any-grant flag.
- mux_rr holds the registers and the data select.

## Test plan
- Reset then idle:
  - Stimulus: reset_L=0 with all vacio=0 and enb=1.
  - Required: all pops 0, all outputs 0.
  - Stimulus: release reset.
  - Required: first pop is pop0.
- All lanes full, enb=1, pausa=0, entrada0..3=4'h1,4'h2,4'h3,4'h4 held:
  - Required: pops cycle 0,1,2,3,0,…
  - Required: salida_mux 1,2,3,4,1,… one cycle later, with selector 0,1,2,3 and valid_mux steady at 1.
  - Required: cuenta_mux increments every cycle.
- Sparse requests, only lanes 1 and 3 non-empty, ptr=0:
  - Required: grants alternate 1,3,1,3.
  - Stimulus: lane 3 empties.
  - Required: lane 1 is granted every cycle.
- Backpressure: pausa=1 for 3 cycles mid-stream.
  - Required: no pops during those cycles.
  - Required: valid_mux=0 for 3 cycles starting one cycle after pausa rises.
  - Required: ptr and cuenta_mux hold. The stream resumes at the next lane in order.
- Counter wrap:
  - Stimulus: 256 grants from reset.
  - Required: cuenta_mux=0, with no disturbance to valid_mux or data.
- Asynchronous reset mid-stream:
  - Stimulus: drop reset_L between clock edges with valid_mux=1.
  - Required: outputs go to 0 immediately and pops drop. After release, lane 0 is granted first.

Source files
------------

// File: rtl/mux_rr_pkg.sv
// Shared constants for the four-lane round-robin merge.
package mux_rr_pkg;
  localparam int NUM_LANES = 4;
  localparam int SEL_WIDTH = 2;
  localparam int CNT_WIDTH = 8;
endpackage

// File: rtl/mux_rr_arbitro.sv
// Combinational rotate-priority encoder: the first requesting lane at or after ptr wins.
module rr_arbitro
  import mux_rr_pkg::*;
(
  input  logic [NUM_LANES-1:0] req_i,
  input  logic [SEL_WIDTH-1:0] ptr_i,
  output logic [NUM_LANES-1:0] gnt_o,
  output logic [SEL_WIDTH-1:0] idx_o,
  output logic                 any_o
);
  logic [SEL_WIDTH-1:0] lane;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    lane  = '0;
    // Walk from lowest to highest priority so the highest-priority request is the last to win.
    for (int k = NUM_LANES - 1; k >= 0; k--) begin
      lane = ptr_i + SEL_WIDTH'(k);
      if (req_i[lane]) begin
        idx_o = lane;
        any_o = 1'b1;
      end
    end
    gnt_o[idx_o] = any_o;
  end
endmodule

// File: rtl/mux_rr.sv
// Four-lane round-robin merge of show-ahead lane FIFOs onto one registered output stream.
module mux_rr
  import mux_rr_pkg::*;
#(
  parameter int DATA_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset_L,
  input  logic                  enb,
  input  logic                  pausa,
  input  logic [DATA_WIDTH-1:0] entrada0_mux,
  input  logic [DATA_WIDTH-1:0] entrada1_mux,
  input  logic [DATA_WIDTH-1:0] entrada2_mux,
  input  logic [DATA_WIDTH-1:0] entrada3_mux,
  input  logic                  vacio0_mux,
  input  logic                  vacio1_mux,
  input  logic                  vacio2_mux,
  input  logic                  vacio3_mux,
  output logic                  pop0_mux,
  output logic                  pop1_mux,
  output logic                  pop2_mux,
  output logic                  pop3_mux,
  output logic [DATA_WIDTH-1:0] salida_mux,
  output logic                  valid_mux,
  output logic [SEL_WIDTH-1:0]  selector_mux,
  output logic [CNT_WIDTH-1:0]  cuenta_mux
);
  logic [NUM_LANES-1:0]  req;
  logic [NUM_LANES-1:0]  gnt;
  logic [SEL_WIDTH-1:0]  idx;
  logic                  any_gnt;
  logic                  allow;
  logic [DATA_WIDTH-1:0] lane_data [NUM_LANES];
  logic [DATA_WIDTH-1:0] salida_q, salida_d;
  logic                  valid_q, valid_d;
  logic [SEL_WIDTH-1:0]  sel_q, sel_d;
  logic [SEL_WIDTH-1:0]  ptr_q, ptr_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

  // reset_L gates the requests so pops fall the instant reset is asserted.
  assign allow = enb & ~pausa & reset_L;
  assign req   = ~{vacio3_mux, vacio2_mux, vacio1_mux, vacio0_mux} & {NUM_LANES{allow}};

  rr_arbitro u_arb (
    .req_i (req),
    .ptr_i (ptr_q),
    .gnt_o (gnt),
    .idx_o (idx),
    .any_o (any_gnt)
  );

  assign {pop3_mux, pop2_mux, pop1_mux, pop0_mux} = gnt;

  assign lane_data[0] = entrada0_mux;
  assign lane_data[1] = entrada1_mux;
  assign lane_data[2] = entrada2_mux;
  assign lane_data[3] = entrada3_mux;

  always_comb begin
    salida_d = '0;
    valid_d  = 1'b0;
    sel_d    = sel_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    if (any_gnt) begin
      salida_d = lane_data[idx];
      valid_d  = 1'b1;
      sel_d    = idx;
      ptr_d    = idx + 2'd1;
      cnt_d    = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      salida_q <= '0;
      valid_q  <= 1'b0;
      sel_q    <= '0;
      ptr_q    <= '0;
      cnt_q    <= '0;
    end else begin
      salida_q <= salida_d;
      valid_q  <= valid_d;
      sel_q    <= sel_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign salida_mux   = salida_q;
  assign valid_mux    = valid_q;
  assign selector_mux = sel_q;
  assign cuenta_mux   = cnt_q;
endmodule
